// File: rtl/mapped_ram_pkg.sv
// Shared definitions for mapped_ram: sweep FSM encoding and default parameter values.
// Also holds the write-protect range test used by both the bus and the clear engine.
package mapped_ram_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

    localparam int unsigned DEF_ADDR_W     = 19;
    localparam int unsigned DEF_DATA_W     = 8;
    localparam int unsigned DEF_DEPTH_LOG2 = 8;
    localparam logic [18:0] DEF_BASE       = 19'h0FF00;
    localparam int unsigned DEF_WP_WORDS   = 0;
    localparam logic [7:0]  DEF_FILL       = 8'h00;

    // Offsets are zero-extended to 32 bits so the compare is always unsigned.
    function automatic logic in_wp_range(input logic [31:0] off, input int unsigned wp_words);
        return off < wp_words;
    endfunction

endpackage

// File: rtl/ram_core.sv
// Simple dual-port storage: one synchronous write port, one registered read port.
// Read is read-first: a same-cycle write to the read address returns the old word.
module ram_core #(
    parameter int unsigned AW        = 8,
    parameter int unsigned DW        = 8,
    parameter              INIT_FILE = ""
) (
    input  logic          clk_i,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [DW-1:0] wr_data_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic [DW-1:0] rd_data_o
);

    logic [DW-1:0] mem_q [2**AW];
    logic [DW-1:0] rd_data_q;

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        rd_data_q <= mem_q[rd_addr_i];
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/mapped_ram.sv
// Bus-mapped RAM window with optional write protection and a fill/clear sweep engine.
// Reads return one cycle later; bus access is locked out (reads zero, writes dropped) while busy.
module mapped_ram
    import mapped_ram_pkg::*;
#(
    parameter int unsigned           ADDR_W     = DEF_ADDR_W,
    parameter int unsigned           DATA_W     = DEF_DATA_W,
    parameter int unsigned           DEPTH_LOG2 = DEF_DEPTH_LOG2,
    parameter logic [ADDR_W-1:0]     BASE       = ADDR_W'(DEF_BASE),
    parameter int unsigned           WP_WORDS   = DEF_WP_WORDS,
    parameter logic [DATA_W-1:0]     FILL       = DATA_W'(DEF_FILL),
    parameter                        INIT_FILE  = ""
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    input  logic              write_en,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              rd_valid,
    input  logic              wp_en,
    input  logic              clear_req,
    output logic              busy
);

    state_e                  state_q, state_d;
    logic [DEPTH_LOG2-1:0]   cnt_q, cnt_d;
    logic                    rd_valid_q, rd_valid_d;

    logic                    hit;
    logic [DEPTH_LOG2-1:0]   offset;
    logic                    idle;
    logic                    bus_wp_blk;
    logic                    clr_wp_skip;
    logic                    bus_we;
    logic                    clr_we;

    logic                    ram_we;
    logic [DEPTH_LOG2-1:0]   ram_waddr;
    logic [DATA_W-1:0]       ram_wdata;
    logic [DATA_W-1:0]       ram_rdata;

    assign hit    = (address[ADDR_W-1:DEPTH_LOG2] == BASE[ADDR_W-1:DEPTH_LOG2]);
    assign offset = address[DEPTH_LOG2-1:0];
    assign idle   = (state_q == ST_IDLE);

    assign bus_wp_blk  = wp_en && in_wp_range(32'(offset), WP_WORDS);
    assign clr_wp_skip = wp_en && in_wp_range(32'(cnt_q), WP_WORDS);
    assign bus_we      = write_en && hit && idle && !bus_wp_blk;
    assign clr_we      = !idle && !clr_wp_skip;

    // Single write port: the sweep owns it while busy; reset blocks every write.
    assign ram_we    = !reset && (idle ? bus_we : clr_we);
    assign ram_waddr = idle ? offset : cnt_q;
    assign ram_wdata = idle ? data_in : FILL;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rd_valid_d = hit && idle;
        case (state_q)
            ST_IDLE: begin
                if (clear_req) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end
            end
            ST_CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (&cnt_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    ram_core #(
        .AW        (DEPTH_LOG2),
        .DW        (DATA_W),
        .INIT_FILE (INIT_FILE)
    ) u_ram_core (
        .clk_i     (clock),
        .wr_en_i   (ram_we),
        .wr_addr_i (ram_waddr),
        .wr_data_i (ram_wdata),
        .rd_addr_i (offset),
        .rd_data_o (ram_rdata)
    );

    // The raw RAM register is not reset, so the valid flag masks it to zero.
    assign data_out = rd_valid_q ? ram_rdata : '0;
    assign rd_valid = rd_valid_q;
    assign busy     = !idle;

endmodule

// File: tb/tb_mapped_ram.sv
// Bench for mapped_ram: directed vector table, busy-window sequences and random traffic vs a reference model.
module tb_mapped_ram;

    localparam int          DEPTH = 256;
    localparam int          WPW   = 16;
    localparam logic [7:0]  FILLV = 8'hEE;
    localparam logic [18:0] BASEV = 19'h0FF00;

    logic        clock;
    logic        reset;
    logic [18:0] address;
    logic        write_en;
    logic [7:0]  data_in;
    logic [7:0]  data_out;
    logic        rd_valid;
    logic        wp_en;
    logic        clear_req;
    logic        busy;

    mapped_ram #(
        .ADDR_W     (19),
        .DATA_W     (8),
        .DEPTH_LOG2 (8),
        .BASE       (BASEV),
        .WP_WORDS   (WPW),
        .FILL       (FILLV),
        .INIT_FILE  ("")
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .address   (address),
        .write_en  (write_en),
        .data_in   (data_in),
        .data_out  (data_out),
        .rd_valid  (rd_valid),
        .wp_en     (wp_en),
        .clear_req (clear_req),
        .busy      (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: word array plus the number of sweep cycles still to run.
    logic [7:0] mm [DEPTH];
    int         left = 0;
    logic [7:0] exp_dout;
    logic       exp_valid;
    logic       exp_busy;

    task automatic model_step(input logic rst, input logic [18:0] a, input logic we,
                              input logic [7:0] d, input logic wp, input logic clr);
        int off;
        int idx;
        logic hit;
        off = int'(a[7:0]);
        hit = ((a >> 8) == (BASEV >> 8));
        if (rst) begin
            exp_dout  = 8'h00;
            exp_valid = 1'b0;
            left      = 0;
        end else if (left > 0) begin
            idx = DEPTH - left;
            if (!(wp && idx < WPW)) mm[idx] = FILLV;
            exp_dout  = 8'h00;
            exp_valid = 1'b0;
            left      = left - 1;
        end else begin
            exp_valid = hit;
            exp_dout  = hit ? mm[off] : 8'h00;
            if (we && hit && !(wp && off < WPW)) mm[off] = d;
            if (clr) left = DEPTH;
        end
        exp_busy = (left > 0);
    endtask

    // Inputs applied at the falling edge, model advanced at the rising edge, outputs sampled at the next falling edge.
    task automatic cycle(input logic rst, input logic [18:0] a, input logic we,
                         input logic [7:0] d, input logic wp, input logic clr);
        reset     = rst;
        address   = a;
        write_en  = we;
        data_in   = d;
        wp_en     = wp;
        clear_req = clr;
        @(posedge clock);
        model_step(rst, a, we, d, wp, clr);
        @(negedge clock);
    endtask

    task automatic check(input string name, input logic [7:0] ed, input logic ev, input logic eb);
        n_cmp++;
        if (data_out !== ed || rd_valid !== ev || busy !== eb) begin
            n_bad++;
            $display("FAIL %s: got data_out=%h rd_valid=%b busy=%b, want %h %b %b",
                     name, data_out, rd_valid, busy, ed, ev, eb);
        end
    endtask

    task automatic check_model(input string name);
        check(name, exp_dout, exp_valid, exp_busy);
    endtask

    typedef struct {
        logic        rst;
        logic [18:0] a;
        logic        we;
        logic [7:0]  d;
        logic        wp;
        logic        clr;
        logic [7:0]  ed;
        logic        ev;
        logic        eb;
    } vec_t;

    function automatic vec_t mk(input logic rst, input logic [18:0] a, input logic we, input logic [7:0] d,
                                input logic wp, input logic clr, input logic [7:0] ed, input logic ev, input logic eb);
        vec_t v;
        v.rst = rst; v.a = a; v.we = we; v.d = d; v.wp = wp; v.clr = clr;
        v.ed = ed; v.ev = ev; v.eb = eb;
        return v;
    endfunction

    vec_t vt [20];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_cnt;
        int low_cnt;
        logic [7:0] rnd;

        // Directed vectors; memory is all FILL when they start.
        vt[0]  = mk(0, 19'h0FF10, 1, 8'hA5, 0, 0, 8'hEE, 1, 0);
        vt[1]  = mk(0, 19'h0FF10, 0, 8'h00, 0, 0, 8'hA5, 1, 0);
        vt[2]  = mk(0, 19'h0FE10, 1, 8'h3C, 0, 0, 8'h00, 0, 0);
        vt[3]  = mk(0, 19'h0FE10, 0, 8'h00, 0, 0, 8'h00, 0, 0);
        vt[4]  = mk(0, 19'h0FF10, 0, 8'h00, 0, 0, 8'hA5, 1, 0);
        vt[5]  = mk(0, 19'h0FF05, 1, 8'h77, 1, 0, 8'hEE, 1, 0);
        vt[6]  = mk(0, 19'h0FF05, 0, 8'h00, 1, 0, 8'hEE, 1, 0);
        vt[7]  = mk(0, 19'h0FF10, 1, 8'h77, 1, 0, 8'hA5, 1, 0);
        vt[8]  = mk(0, 19'h0FF10, 0, 8'h00, 1, 0, 8'h77, 1, 0);
        vt[9]  = mk(0, 19'h0FF05, 1, 8'h77, 0, 0, 8'hEE, 1, 0);
        vt[10] = mk(0, 19'h0FF05, 0, 8'h00, 0, 0, 8'h77, 1, 0);
        vt[11] = mk(0, 19'h0FF20, 1, 8'h11, 0, 0, 8'hEE, 1, 0);
        vt[12] = mk(0, 19'h0FF20, 1, 8'h22, 0, 0, 8'h11, 1, 0);
        vt[13] = mk(0, 19'h0FF20, 0, 8'h00, 0, 0, 8'h22, 1, 0);
        vt[14] = mk(1, 19'h0FF20, 1, 8'h99, 0, 0, 8'h00, 0, 0);
        vt[15] = mk(0, 19'h0FF20, 0, 8'h00, 0, 0, 8'h22, 1, 0);
        vt[16] = mk(1, 19'h0FF20, 0, 8'h00, 0, 1, 8'h00, 0, 0);
        vt[17] = mk(0, 19'h0FF0F, 1, 8'h5A, 1, 0, 8'hEE, 1, 0);
        vt[18] = mk(0, 19'h0FF0F, 0, 8'h00, 0, 0, 8'hEE, 1, 0);
        vt[19] = mk(0, 19'h7FF10, 0, 8'h00, 0, 0, 8'h00, 0, 0);

        reset = 1'b1; address = '0; write_en = 0; data_in = '0; wp_en = 0; clear_req = 0;
        @(negedge clock);

        cycle(1, BASEV, 0, 8'h00, 0, 0);
        check("reset_state", 8'h00, 1'b0, 1'b0);
        cycle(1, 19'h0FF10, 1, 8'hAB, 0, 1);
        check("reset_priority", 8'h00, 1'b0, 1'b0);

        // Full sweep: busy window length, dropped write while busy, then every offset reads FILL.
        cycle(0, BASEV, 0, 8'h00, 0, 1);
        check_model("clear_start");
        busy_cnt = 0;
        for (int i = 0; i < 1000 && busy === 1'b1; i++) begin
            busy_cnt++;
            cycle(0, 19'h0FF30, (i == 5), 8'h55, 0, 0);
            check_model("sweep_run");
        end
        n_cmp++;
        if (busy_cnt != DEPTH) begin
            n_bad++;
            $display("FAIL busy_length: got %0d cycles, want %0d", busy_cnt, DEPTH);
        end
        for (int o = 0; o < DEPTH; o++) begin
            cycle(0, BASEV | 19'(o), 0, 8'h00, 0, 0);
            check("fill_readback", FILLV, 1'b1, 1'b0);
        end

        for (int i = 0; i < 20; i++) begin
            cycle(vt[i].rst, vt[i].a, vt[i].we, vt[i].d, vt[i].wp, vt[i].clr);
            check($sformatf("vec%0d", i), vt[i].ed, vt[i].ev, vt[i].eb);
        end

        // Randomise contents, then abort a write-protected sweep with reset after 100 busy cycles.
        for (int o = 0; o < DEPTH; o++) begin
            rnd = 8'($urandom);
            cycle(0, BASEV | 19'(o), 1, rnd, 0, 0);
        end
        cycle(0, BASEV, 0, 8'h00, 1, 1);
        check_model("wp_sweep_start");
        for (int i = 0; i < 100; i++) begin
            cycle(0, BASEV, 0, 8'h00, 1, 0);
            check_model("wp_sweep_run");
        end
        cycle(1, BASEV, 0, 8'h00, 1, 0);
        check("abort_reset", 8'h00, 1'b0, 1'b0);
        for (int o = 0; o < DEPTH; o++) begin
            cycle(0, BASEV | 19'(o), 0, 8'h00, 0, 0);
            check_model("abort_readback");
        end

        // clear_req held across sweeps: one idle cycle between back-to-back sweeps.
        cycle(0, BASEV, 0, 8'h00, 0, 1);
        check_model("held_start");
        low_cnt = 0;
        for (int i = 0; i < 599; i++) begin
            cycle(0, BASEV | 19'(i % DEPTH), 1, 8'h42, 0, 1);
            check_model("held_run");
            if (busy !== 1'b1) low_cnt++;
        end
        n_cmp++;
        if (low_cnt != 2) begin
            n_bad++;
            $display("FAIL held_clear_gaps: got %0d idle cycles, want 2", low_cnt);
        end
        for (int i = 0; i < 400 && busy === 1'b1; i++) begin
            cycle(0, BASEV, 0, 8'h00, 0, 0);
            check_model("held_drain");
        end

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            logic [18:0] a;
            logic        rr;
            logic        cc;
            if ($urandom_range(0, 99) < 85) a = BASEV | 19'($urandom_range(0, 255));
            else                            a = 19'($urandom);
            rr = ($urandom_range(0, 399) == 0);
            cc = ($urandom_range(0, 149) == 0);
            cycle(rr, a, 1'($urandom), 8'($urandom), 1'($urandom), cc);
            check_model("random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
